// File: rtl/cpu_pipe_pkg.sv
// Shared types and defaults for the 5-stage pipeline sequencing controller.
package cpu_pipe_pkg;

  typedef enum logic [2:0] {
    BOOT     = 3'd0,
    RUN      = 3'd1,
    BR_WAIT  = 3'd2,
    MEM_WAIT = 3'd3,
    HALT     = 3'd4
  } pipe_state_t;

  localparam int MEM_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/cpu_pipe_perf.sv
// Saturating stall/flush performance counters for cpu_pipe_ctrl.
module cpu_pipe_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc) stall_cnt <= sat_inc(stall_cnt);
      if (flush_inc) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: rtl/cpu_pipe_ctrl.sv
// Pipeline sequencing controller: stage enables, bubbles, flushes and memory watchdog.
// Optional performance counters are built when CPU_PIPE_PERF_EN is defined.
module cpu_pipe_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rw_stall,
  input  logic             jb_stall,
  input  logic             br_resolve,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_dec_en,
  output logic             dec_exec_en,
  output logic             exec_mem_en,
  output logic             mem_wb_en,
  output logic             dec_bubble,
  output logic             if_flush,
  output logic             pc_load,
  output logic             halted,
  output logic             timeout_err,
`ifdef CPU_PIPE_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic [2:0]       state
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT - 1);

  pipe_state_t       state_q, state_nx, ret_q, ret_nx, eff_st;
  logic [WCNT_W-1:0] wcnt_q, wcnt_nx;
  logic              terr_q, terr_nx;
  logic              mem_stall;

  assign mem_stall   = mem_req & ~mem_ack;
  assign state       = state_q;
  assign timeout_err = terr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      ret_q   <= RUN;
      wcnt_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      ret_q   <= ret_nx;
      wcnt_q  <= wcnt_nx;
      terr_q  <= terr_nx;
    end
  end

  // The ack cycle of a memory wait behaves exactly like the saved state.
  always_comb begin
    state_nx    = state_q;
    ret_nx      = ret_q;
    wcnt_nx     = wcnt_q;
    terr_nx     = terr_q;
    pc_en       = 1'b0;
    if_dec_en   = 1'b0;
    dec_exec_en = 1'b0;
    exec_mem_en = 1'b0;
    mem_wb_en   = 1'b0;
    dec_bubble  = 1'b0;
    if_flush    = 1'b0;
    pc_load     = 1'b0;
    halted      = 1'b0;
    eff_st      = state_q;
    if (state_q == MEM_WAIT && mem_ack) eff_st = ret_q;

    case (eff_st)
      BOOT: state_nx = RUN;
      RUN: begin
        if (mem_stall) begin
          state_nx = MEM_WAIT;
          ret_nx   = RUN;
          wcnt_nx  = '0;
        end else begin
          pc_en       = ~(jb_stall | rw_stall);
          if_dec_en   = ~(jb_stall | rw_stall);
          dec_bubble  = jb_stall | rw_stall;
          dec_exec_en = 1'b1;
          exec_mem_en = 1'b1;
          mem_wb_en   = 1'b1;
          state_nx    = jb_stall ? BR_WAIT : RUN;
        end
      end
      BR_WAIT: begin
        if (mem_stall) begin
          state_nx = MEM_WAIT;
          ret_nx   = BR_WAIT;
          wcnt_nx  = '0;
        end else begin
          dec_bubble  = 1'b1;
          dec_exec_en = 1'b1;
          exec_mem_en = 1'b1;
          mem_wb_en   = 1'b1;
          state_nx    = BR_WAIT;
          if (br_resolve) begin
            state_nx = RUN;
            pc_en    = 1'b1;
            pc_load  = br_taken;
            if_flush = br_taken;
          end
        end
      end
      MEM_WAIT: begin
        if (wcnt_q == WCNT_MAX) begin
          state_nx = HALT;
          terr_nx  = 1'b1;
        end else begin
          wcnt_nx = wcnt_q + WCNT_W'(1);
        end
      end
      HALT: begin
        halted = 1'b1;
        if (resume) begin
          state_nx = RUN;
          terr_nx  = 1'b0;
        end
      end
      default: state_nx = BOOT;
    endcase
  end

`ifdef CPU_PIPE_PERF_EN
  logic stall_inc;
  assign stall_inc = ~pc_en & (state_q != BOOT) & (state_q != HALT);

  cpu_pipe_perf #(.CNT_W(CNT_W)) u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall_inc (stall_inc),
    .flush_inc (if_flush),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// Directed bench for cpu_pipe_ctrl with a short watchdog and narrow counters.
module tb_cpu_pipe_ctrl;
  import cpu_pipe_pkg::*;

  localparam int CNT_W = 4;

  // {pc_en, if_dec_en, dec_exec_en, exec_mem_en, mem_wb_en, dec_bubble, if_flush, pc_load, halted, timeout_err}
  localparam logic [9:0] O_NONE  = 10'b00000_00000;
  localparam logic [9:0] O_ALL   = 10'b11111_00000;
  localparam logic [9:0] O_STALL = 10'b00111_10000;
  localparam logic [9:0] O_TAKEN = 10'b10111_11100;
  localparam logic [9:0] O_NTKN  = 10'b10111_10000;
  localparam logic [9:0] O_HALT  = 10'b00000_00011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rw_stall = 0, jb_stall = 0, br_resolve = 0, br_taken = 0;
  logic mem_req = 0, mem_ack = 0, resume = 0;
  logic pc_en, if_dec_en, dec_exec_en, exec_mem_en, mem_wb_en;
  logic dec_bubble, if_flush, pc_load, halted, timeout_err;
  logic [2:0] state;
`ifdef CPU_PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu_pipe_ctrl #(.MEM_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rw_stall    (rw_stall),
    .jb_stall    (jb_stall),
    .br_resolve  (br_resolve),
    .br_taken    (br_taken),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .resume      (resume),
    .pc_en       (pc_en),
    .if_dec_en   (if_dec_en),
    .dec_exec_en (dec_exec_en),
    .exec_mem_en (exec_mem_en),
    .mem_wb_en   (mem_wb_en),
    .dec_bubble  (dec_bubble),
    .if_flush    (if_flush),
    .pc_load     (pc_load),
    .halted      (halted),
    .timeout_err (timeout_err),
`ifdef CPU_PIPE_PERF_EN
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
`endif
    .state       (state)
  );

  task automatic chk(input string tag, input logic [2:0] est, input logic [9:0] eo);
    logic [9:0] obs;
    obs = {pc_en, if_dec_en, dec_exec_en, exec_mem_en, mem_wb_en,
           dec_bubble, if_flush, pc_load, halted, timeout_err};
    n_checks++;
    assert (state === est) else begin
      n_errors++;
      $error("FAIL %s.state: observed %0d expected %0d", tag, state, est);
    end
    n_checks++;
    assert (obs === eo) else begin
      n_errors++;
      $error("FAIL %s.outs: observed %b expected %b", tag, obs, eo);
    end
  endtask

  task automatic chk_perf(input string tag, input int es, input int ef);
`ifdef CPU_PIPE_PERF_EN
    n_checks++;
    assert (stall_cnt === CNT_W'(es)) else begin
      n_errors++;
      $error("FAIL %s.stall_cnt: observed %0d expected %0d", tag, stall_cnt, es);
    end
    n_checks++;
    assert (flush_cnt === CNT_W'(ef)) else begin
      n_errors++;
      $error("FAIL %s.flush_cnt: observed %0d expected %0d", tag, flush_cnt, ef);
    end
`else
    if (tag.len() == 0) $display("%0d %0d", es, ef);
`endif
  endtask

  // Check the current cycle's outputs, then advance to just after the next edge.
  task automatic step(input string tag, input logic [2:0] est, input logic [9:0] eo);
    #1;
    chk(tag, est, eo);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held, then released between edges
    #12;
    chk("reset", BOOT, O_NONE);
    chk_perf("reset", 0, 0);
    rst_n = 1'b1;
    step("boot", BOOT, O_NONE);
    step("run", RUN, O_ALL);

    // RAW hazard for two cycles
    rw_stall = 1;
    step("rw1", RUN, O_STALL);
    step("rw2", RUN, O_STALL);
    rw_stall = 0;
    step("rw_end", RUN, O_ALL);

    // Taken branch after three BR_WAIT cycles
    jb_stall = 1;
    step("jb", RUN, O_STALL);
    jb_stall = 0;
    rw_stall = 1;
    step("brw1", BR_WAIT, O_STALL);
    rw_stall = 0;
    step("brw2", BR_WAIT, O_STALL);
    br_resolve = 1; br_taken = 1;
    step("taken", BR_WAIT, O_TAKEN);
    br_resolve = 0; br_taken = 0;
    step("post_taken", RUN, O_ALL);
    chk_perf("branch", 5, 1);

    // Not-taken branch
    jb_stall = 1;
    step("jb_nt", RUN, O_STALL);
    jb_stall = 0; br_resolve = 1;
    step("ntaken", BR_WAIT, O_NTKN);
    br_resolve = 0;

    // Memory stall inside BR_WAIT beats a simultaneous resolve
    jb_stall = 1;
    step("jb_mem", RUN, O_STALL);
    jb_stall = 0; mem_req = 1; br_resolve = 1; br_taken = 1;
    step("bw_mem", BR_WAIT, O_NONE);
    br_resolve = 0; br_taken = 0;
    for (int i = 0; i < 4; i++) step("mw_br", MEM_WAIT, O_NONE);
    mem_ack = 1;
    step("mw_ack", MEM_WAIT, O_STALL);
    mem_req = 0; mem_ack = 0;
    step("bw_back", BR_WAIT, O_STALL);
    br_resolve = 1;
    step("bw_res", BR_WAIT, O_NTKN);
    br_resolve = 0;
    step("run2", RUN, O_ALL);
    chk_perf("mem_br", 14, 1);

    // Watchdog: eight MEM_WAIT cycles then HALT
    mem_req = 1;
    step("mem_run", RUN, O_NONE);
    for (int i = 0; i < 8; i++) step("mw_to", MEM_WAIT, O_NONE);
    step("halt1", HALT, O_HALT);
    step("halt2", HALT, O_HALT);
    chk_perf("sat", 15, 1);
    resume = 1;
    step("resume", HALT, O_HALT);
    resume = 0; mem_req = 0;
    step("resumed", RUN, O_ALL);
    resume = 1;
    step("res_ign", RUN, O_ALL);
    resume = 0;
    step("run3", RUN, O_ALL);

    // Asynchronous reset in the middle of a memory wait
    mem_req = 1;
    step("mem_run2", RUN, O_NONE);
    step("mw_rst", MEM_WAIT, O_NONE);
    rst_n = 1'b0;
    #1;
    chk("mid_rst", BOOT, O_NONE);
    chk_perf("mid_rst", 0, 0);
    rst_n = 1'b1; mem_req = 0;
    step("boot2", BOOT, O_NONE);
    #1;
    chk("run4", RUN, O_ALL);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_pipe_ctrl.md
# cpu_pipe_ctrl

Pipeline sequencing controller for the 5-stage accelerator CPU (IF/DEC/EXEC/MEM/WB). It turns the combinational hazard and branch stall indications, plus the data-memory request/acknowledge handshake, into per-stage register enables, bubble-insert and flush strobes. A small FSM holds branch-resolution and memory-wait episodes. A watchdog halts the core on a hung memory access.

## Interface
- `MEM_TIMEOUT`, default 1024: maximum cycles waiting for `mem_ack` before entering HALT. Legal range is ≥2.
- `CNT_W`, default 32: width of the performance counters.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rw_stall` in 1: read-after-write hazard on the IF instruction.
- `jb_stall` in 1: jump/branch in flight in DEC or EXEC.
- `br_resolve` in 1: branch outcome valid this cycle (EXEC).
- `br_taken` in 1: resolved branch is taken. Qualified by `br_resolve`.
- `mem_req` in 1: MEM stage holds a load/store.
- `mem_ack` in 1: data memory completes the access this cycle.
- `resume` in 1: single-cycle pulse; leaves HALT.
- `pc_en` out 1: PC register enable.
- `if_dec_en`, `dec_exec_en`, `exec_mem_en`, `mem_wb_en` out 1 each: pipeline register enables.
- `dec_bubble` out 1: load NOP into DEC/EXEC instead of DEC output.
- `if_flush` out 1: clear IF/DEC to NOP.
- `pc_load` out 1: PC takes branch target.
- `halted` out 1: core is halted.
- `timeout_err` out 1: sticky flag; HALT was entered by the watchdog.
- `state` out 3: current FSM state, for debug.
- `stall_cnt`, `flush_cnt` out CNT_W each: performance counters. Present only with `CPU_PIPE_PERF_EN`.

## Operation
- States: BOOT, RUN, BR_WAIT, MEM_WAIT, HALT.
- Reset is asynchronous to BOOT. In BOOT all enables, strobes and `halted` are 0. BOOT always moves to RUN on the next cycle.
- Memory stall is `mem_req & ~mem_ack`. Priority order: HALT, then memory stall, then branch, then hazard.
- **RUN**
  - All enables are 1 by default.
  - On memory stall: go to MEM_WAIT with all enables 0 this cycle. Save return state RUN.
  - Else on `jb_stall`: go to BR_WAIT. This cycle drives `pc_en`=0, `if_dec_en`=0 and `dec_bubble`=1. Downstream enables stay 1.
  - Else on `rw_stall`: stay in RUN. Same outputs as the branch case: `pc_en`=0, `if_dec_en`=0, `dec_bubble`=1, downstream enables 1.
- **BR_WAIT**
  - Drives `pc_en`=0, `if_dec_en`=0, `dec_bubble`=1; downstream enables 1.
  - On `br_resolve` with `br_taken`=1: pulse `pc_load`, `pc_en` and `if_flush` for one cycle, then go to RUN.
  - On `br_resolve` with `br_taken`=0: `pc_en`=1, go to RUN.
  - A memory stall takes precedence over `br_resolve`. Go to MEM_WAIT with return state BR_WAIT. The branch outcome is re-sampled after return.
- **MEM_WAIT**
  - All enables 0; wait counter increments.
  - On `mem_ack`: return to the saved state. Enables are recomputed that cycle as for the saved state.
  - When the counter reaches `MEM_TIMEOUT`-1: go to HALT and set `timeout_err`.
- **HALT**
  - All enables 0; `halted`=1.
  - `resume` returns to RUN and clears `timeout_err`. `resume` in any other state is ignored.
- The wait counter is $clog2(MEM_TIMEOUT) bits wide and clears on every MEM_WAIT entry.
- `rw_stall` in BR_WAIT or MEM_WAIT is ignored.

## Timing
- Enables and strobes are combinational from state and inputs, giving zero-cycle stall response. The hazard inputs are sampled in the same cycle.
- State, saved return state, wait counter, `timeout_err` and the counters are registered.
- Reset values: state BOOT. `timeout_err`=0. Counters 0. With `rw_stall`, `jb_stall` and `mem_req` low, every output is 0.
- Branch penalty when not stalled by memory: one cycle per BR_WAIT cycle, plus the flush cycle if taken.
- Reset asserted mid-episode aborts it immediately with no strobe emitted.

## Configuration
- `CPU_PIPE_PERF_EN` defined:
  - `stall_cnt` increments each cycle that `pc_en`=0 outside BOOT/HALT.
  - `flush_cnt` increments on each `if_flush`.
  - Both saturate at all-ones.
- Undefined: the counter ports and logic are absent.

## Structure
- `cpu_pipe_pkg` holds:
  - the `pipe_state_t` enum with its 3-bit encoding: BOOT=0, RUN=1, BR_WAIT=2, MEM_WAIT=3, HALT=4;
  - the `MEM_TIMEOUT` default.
- Sub-module `cpu_pipe_perf` holds the two saturating counters. It is instantiated under the macro.

## Test plan
- Reset released with all inputs low → `state` reads BOOT, then RUN on the next cycle. In RUN all four enables and `pc_en` are 1.
- `rw_stall` held 2 cycles in RUN → `pc_en`=0 and `dec_bubble`=1 for exactly 2 cycles; `exec_mem_en` stays 1; state stays RUN.
- `jb_stall`, then `br_resolve`=1 with `br_taken`=1 three cycles later → BR_WAIT for 3 cycles, then a single-cycle `pc_load`/`if_flush` pulse; `flush_cnt`=1.
- In BR_WAIT, `mem_req`=1 with `mem_ack` delayed 5 cycles → MEM_WAIT for 5 cycles with all enables 0, then return to BR_WAIT.
- `MEM_TIMEOUT`=8 and `mem_req` stuck high → HALT after 8 cycles with `halted`=1 and `timeout_err`=1. A `resume` pulse returns to RUN and clears `timeout_err`.
- `rst_n` dropped mid-MEM_WAIT → `state` reads BOOT immediately, `timeout_err` is 0 and the counters are 0.
